// File: rtl/ahb_lite_copy_master_if.sv
// AHB-Lite bus bundle between the copy master and its slave(s).
interface ahb_lite_copy_master_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_copy_master.sv
// Single-channel AHB-Lite word copy engine: one non-pipelined read then one
// write per word, stops on completion or on the first error response.
module ahb_lite_copy_master #(
  parameter int CNT_W          = 16,
  parameter bit ADDR_ALIGN_CHK = 1'b1
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  ahb_lite_copy_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_FIN
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  state_t           state, state_nxt;
  logic [31:0]      src_ptr, dst_ptr, data_buf;
  logic [CNT_W-1:0] remaining;
  logic             err_q;

  function automatic logic [31:0] align(input logic [31:0] a);
    return ADDR_ALIGN_CHK ? {a[31:2], 2'b00} : a;
  endfunction

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // An error response is acted on in its first cycle (HREADY still low);
  // the cancel is legal because HTRANS is already IDLE in data phases.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = (word_count != '0) ? S_RD_ADDR : S_FIN;
      S_RD_ADDR: if (bus.HREADY) state_nxt = S_RD_DATA;
      S_RD_DATA: if (bus.HRESP) state_nxt = S_FIN;
                 else if (bus.HREADY) state_nxt = S_WR_ADDR;
      S_WR_ADDR: if (bus.HREADY) state_nxt = S_WR_DATA;
      S_WR_DATA: if (bus.HRESP) state_nxt = S_FIN;
                 else if (bus.HREADY)
                   state_nxt = (remaining == CNT_W'(1)) ? S_FIN : S_RD_ADDR;
      S_FIN:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      data_buf  <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          err_q <= 1'b0;
          if (word_count != '0) begin
            src_ptr   <= align(src_addr);
            dst_ptr   <= align(dst_addr);
            remaining <= word_count;
          end
        end
        S_RD_DATA: begin
          if (bus.HRESP)       err_q    <= 1'b1;
          else if (bus.HREADY) data_buf <= bus.HRDATA;
        end
        S_WR_DATA: begin
          if (bus.HRESP) err_q <= 1'b1;
          else if (bus.HREADY) begin
            src_ptr   <= src_ptr + 32'd4;
            dst_ptr   <= dst_ptr + 32'd4;
            remaining <= remaining - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.HTRANS = TR_IDLE;
    bus.HWRITE = 1'b0;
    bus.HADDR  = src_ptr;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_RD_ADDR: begin
        bus.HTRANS = TR_NONSEQ;
        busy       = 1'b1;
      end
      S_RD_DATA: busy = 1'b1;
      S_WR_ADDR: begin
        bus.HTRANS = TR_NONSEQ;
        bus.HWRITE = 1'b1;
        bus.HADDR  = dst_ptr;
        busy       = 1'b1;
      end
      S_WR_DATA: begin
        bus.HADDR = dst_ptr;
        busy      = 1'b1;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  // data_buf only changes in RD_DATA, so HWDATA is stable across write waits.
  assign bus.HWDATA    = data_buf;
  assign bus.HSIZE     = 3'b010;
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = 4'b0011;
  assign bus.HMASTLOCK = 1'b0;
  assign error         = err_q;

endmodule
